// File: rtl/aes_key_expand_multi.sv
// Iterative AES-128/192/256 key-schedule engine: one schedule word per cycle,
// 128-bit round keys on a valid/ready stream. Optional table: AES_KEY_EXP_STORE_EN.

module aes_sbox (
   input  logic [7:0] a,
   output logic [7:0] s
);

   function automatic logic [7:0] gf_mul(input logic [7:0] x, input logic [7:0] y);
      logic [7:0] p;
      logic [7:0] aa;
      p  = 8'h00;
      aa = x;
      for (int k = 0; k < 8; k++) begin
         if (y[k]) p = p ^ aa;
         aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   logic [7:0] sq;
   logic [7:0] inv;

   // Multiplicative inverse as a^254 (maps 0 to 0), then the affine transform.
   always_comb begin
      sq  = a;
      inv = 8'h01;
      for (int k = 1; k < 8; k++) begin
         sq  = gf_mul(sq, sq);
         inv = gf_mul(inv, sq);
      end
      s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
          {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
   end

endmodule

module aes_key_expand_multi #(
   parameter int MAX_NK = 8,
   parameter int RK_NUM = 15
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         key_valid,
   output logic         key_ready,
   input  logic [1:0]   key_mode,
   input  logic [255:0] key,
   input  logic         abort,
   output logic         rk_valid,
   input  logic         rk_ready,
   output logic [127:0] rk_data,
   output logic [3:0]   rk_idx,
   output logic         rk_last,
   output logic         busy,
   output logic         err
`ifdef AES_KEY_EXP_STORE_EN
   ,
   input  logic [3:0]   rd_addr,
   output logic [127:0] rd_data,
   output logic         tbl_valid
`endif
);

   // Handshakes: a key is taken when key_valid && key_ready at a rising edge;
   // a round key transfers when rk_valid && rk_ready, and rk_data/rk_idx/rk_last
   // hold steady while rk_valid is high and rk_ready is low.

   typedef enum logic [1:0] {IDLE, EXPAND, DRAIN} state_t;

   localparam int KW = MAX_NK * 32;

   state_t       state;
   logic [KW-1:0] key_r;
   logic [31:0]  win [MAX_NK];
   logic [31:0]  acc [3];
   logic [5:0]   wi;
   logic [2:0]   nk_m1;
   logic [2:0]   phase;
   logic [3:0]   nr_r;
   logic [7:0]   rcon;

   logic [2:0]   req_nk_m1;
   logic [3:0]   req_nr;
   logic         mode_ok;
   logic         accept;
   logic         in_key;
   logic [1:0]   slot;
   logic         word_last;
   logic         out_free;
   logic         step;
   logic         rk_fire;
   logic         load_rk;
   logic [127:0] load_data;
   logic [31:0]  sub_in;
   logic [31:0]  sub_out;
   logic [31:0]  t_word;
   logic [31:0]  new_w;

   always_comb begin
      req_nk_m1 = 3'd7;
      req_nr    = 4'd14;
      mode_ok   = 1'b0;
      case (key_mode)
         2'd0: begin req_nk_m1 = 3'd3; req_nr = 4'd10; mode_ok = 1'b1; end
         2'd1: begin req_nk_m1 = 3'd5; req_nr = 4'd12; mode_ok = 1'b1; end
         2'd2: begin req_nk_m1 = 3'd7; req_nr = 4'd14; mode_ok = 1'b1; end
         default: mode_ok = 1'b0;
      endcase
      if (int'(req_nk_m1) + 1 > MAX_NK) mode_ok = 1'b0;
   end

   assign key_ready = rst_n && (state == IDLE);
   assign accept    = (state == IDLE) && key_valid && !abort && mode_ok;
   assign in_key    = (wi <= {3'b000, nk_m1});
   assign slot      = wi[1:0];
   assign word_last = (wi == {nr_r, 2'b11});
   assign rk_fire   = rk_valid && rk_ready;
   assign out_free  = !rk_valid || rk_ready;
   // Only the slot-3 write needs the output register; earlier slots fill regardless.
   assign step      = (state == EXPAND) && !abort && ((slot != 2'd3) || out_free);
   assign load_rk   = step && (slot == 2'd3);

   assign sub_in = (phase == 3'd0) ? {win[0][23:0], win[0][31:24]} : win[0];

   for (genvar b = 0; b < 4; b++) begin : g_sbox
      aes_sbox u_sbox (
         .a (sub_in[8*b +: 8]),
         .s (sub_out[8*b +: 8])
      );
   end

   always_comb begin
      t_word = win[0];
      if (phase == 3'd0)
         t_word = sub_out ^ {rcon, 24'h000000};
      else if (nk_m1 == 3'd7 && phase == 3'd4)
         t_word = sub_out;
      new_w     = in_key ? key_r[KW-1 -: 32] : (win[nk_m1] ^ t_word);
      load_data = {acc[0], acc[1], acc[2], new_w};
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= IDLE;
         busy     <= 1'b0;
         err      <= 1'b0;
         rk_valid <= 1'b0;
         rk_data  <= '0;
         rk_idx   <= '0;
         rk_last  <= 1'b0;
         key_r    <= '0;
         wi       <= '0;
         phase    <= '0;
         nk_m1    <= 3'd3;
         nr_r     <= 4'd10;
         rcon     <= 8'h01;
         for (int k = 0; k < MAX_NK; k++) win[k] <= '0;
         for (int k = 0; k < 3; k++) acc[k] <= '0;
      end else begin
         err <= 1'b0;
         if (rk_fire) begin
            rk_valid <= 1'b0;
            rk_last  <= 1'b0;
         end
         case (state)
            IDLE: begin
               if (key_valid && !abort) begin
                  if (mode_ok) begin
                     key_r <= key[255 -: KW];
                     nk_m1 <= req_nk_m1;
                     nr_r  <= req_nr;
                     wi    <= '0;
                     phase <= '0;
                     rcon  <= 8'h01;
                     state <= EXPAND;
                     busy  <= 1'b1;
                  end else begin
                     err <= 1'b1;
                  end
               end
            end
            EXPAND: begin
               if (step) begin
                  win[0] <= new_w;
                  for (int k = 1; k < MAX_NK; k++) win[k] <= win[k-1];
                  key_r <= key_r << 32;
                  wi    <= wi + 6'd1;
                  phase <= (phase == nk_m1) ? 3'd0 : phase + 3'd1;
                  if (!in_key && phase == 3'd0)
                     rcon <= {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);
                  if (slot != 2'd3) begin
                     acc[slot] <= new_w;
                  end else begin
                     rk_data  <= load_data;
                     rk_idx   <= wi[5:2];
                     rk_last  <= (wi[5:2] == nr_r);
                     rk_valid <= 1'b1;
                  end
                  if (word_last) state <= DRAIN;
               end
            end
            DRAIN: begin
               if (rk_fire) begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
         // Abort drops any pending round key, even one being accepted right now.
         if (abort && state != IDLE) begin
            state    <= IDLE;
            busy     <= 1'b0;
            rk_valid <= 1'b0;
            rk_last  <= 1'b0;
            wi       <= '0;
            phase    <= '0;
            for (int k = 0; k < 3; k++) acc[k] <= '0;
         end
      end
   end

`ifdef AES_KEY_EXP_STORE_EN
   logic [127:0] tbl [RK_NUM];

   always_ff @(posedge clk) begin
      if (load_rk && int'(wi[5:2]) < RK_NUM)
         tbl[wi[5:2]] <= load_data;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         tbl_valid <= 1'b0;
         rd_data   <= '0;
      end else begin
         if (accept || (abort && state != IDLE))
            tbl_valid <= 1'b0;
         else if (state == DRAIN && rk_fire)
            tbl_valid <= 1'b1;
         if (tbl_valid && rd_addr <= nr_r && int'(rd_addr) < RK_NUM)
            rd_data <= tbl[rd_addr];
         else
            rd_data <= '0;
      end
   end
`endif

endmodule

// File: tb/tb_aes_key_expand_multi.sv
// Bench for aes_key_expand_multi: FIPS-197 style reference schedule, directed
// vectors, random keys/modes and random backpressure; AES_KEY_EXP_STORE_EN aware.

module tb_aes_key_expand_multi;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         key_valid = 1'b0;
   logic         key_ready;
   logic [1:0]   key_mode = 2'd0;
   logic [255:0] key = '0;
   logic         abort = 1'b0;
   logic         rk_valid;
   logic         rk_ready = 1'b0;
   logic [127:0] rk_data;
   logic [3:0]   rk_idx;
   logic         rk_last;
   logic         busy;
   logic         err;
`ifdef AES_KEY_EXP_STORE_EN
   logic [3:0]   rd_addr = 4'd0;
   logic [127:0] rd_data;
   logic         tbl_valid;
`endif

   int n_assert = 0;
   int n_fail   = 0;
   logic [127:0] exp_q[$];
   logic [127:0] exp_rk [15];
   logic [7:0]   sbox_t [256];

   always #5 clk = ~clk;

   aes_key_expand_multi dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .key_valid (key_valid),
      .key_ready (key_ready),
      .key_mode  (key_mode),
      .key       (key),
      .abort     (abort),
      .rk_valid  (rk_valid),
      .rk_ready  (rk_ready),
      .rk_data   (rk_data),
      .rk_idx    (rk_idx),
      .rk_last   (rk_last),
      .busy      (busy),
      .err       (err)
`ifdef AES_KEY_EXP_STORE_EN
      ,
      .rd_addr   (rd_addr),
      .rd_data   (rd_data),
      .tbl_valid (tbl_valid)
`endif
   );

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // S-box from the generator walk: p steps through powers of 3, q through powers of 1/3.
   task automatic build_sbox();
      logic [7:0] p, q, x;
      p = 8'h01;
      q = 8'h01;
      do begin
         p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
         q = q ^ (q << 1);
         q = q ^ (q << 2);
         q = q ^ (q << 4);
         if (q[7]) q = q ^ 8'h09;
         x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]} ^ 8'h63;
         sbox_t[p] = x;
      end while (p != 8'h01);
      sbox_t[0] = 8'h63;
   endtask

   function automatic logic [31:0] sub_word(input logic [31:0] v);
      return {sbox_t[v[31:24]], sbox_t[v[23:16]], sbox_t[v[15:8]], sbox_t[v[7:0]]};
   endfunction

   function automatic int model(input logic [1:0] mode, input logic [255:0] k);
      int nk;
      int nr;
      logic [31:0] w [60];
      logic [31:0] t;
      logic [7:0] rc;
      nk = 4 + 2 * int'(mode);
      nr = nk + 6;
      rc = 8'h01;
      exp_q.delete();
      for (int i = 0; i < 4 * (nr + 1); i++) begin
         if (i < nk) begin
            w[i] = k[255 - 32 * i -: 32];
         end else begin
            t = w[i-1];
            if (i % nk == 0) begin
               t = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h000000};
               rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
            end else if (nk == 8 && i % nk == 4) begin
               t = sub_word(t);
            end
            w[i] = w[i-nk] ^ t;
         end
      end
      for (int r = 0; r <= nr; r++) begin
         exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
         exp_q.push_back(exp_rk[r]);
      end
      return nr;
   endfunction

   function automatic logic [255:0] rand256();
      logic [255:0] v;
      for (int j = 0; j < 8; j++) v[32*j +: 32] = $urandom;
      return v;
   endfunction

   task automatic send_key(input logic [1:0] mode, input logic [255:0] k);
      @(negedge clk);
      chk("key_ready_before_key", 128'(key_ready), 128'd1);
      key_valid = 1'b1;
      key_mode  = mode;
      key       = k;
      @(posedge clk);
      @(negedge clk);
      key_valid = 1'b0;
      key_mode  = 2'($urandom_range(0, 3));
      key       = rand256();
   endtask

   // Called at the negedge right after the key handshake edge (cyc = 0).
   task automatic run_stream(input int nr, input bit rnd, input int abort_idx,
                             output logic [127:0] first, output logic [127:0] last);
      int cyc = 0;
      int idx = 0;
      bit done = 1'b0;
      bit seen_valid = 1'b0;
      bit rdy;
      first = '0;
      last  = '0;
      while (!done && cyc < 800) begin
         if (rk_valid) begin
            chk("rk_data", rk_data, exp_q.size() > 0 ? exp_q[0] : 128'hx);
            chk("rk_idx", 128'(rk_idx), 128'(idx));
            chk("rk_last", 128'(rk_last), 128'(idx == nr));
            if (!seen_valid && !rnd) chk("first_rk_cycle", 128'(cyc), 128'd4);
            if (rk_last && !rnd) chk("last_rk_cycle", 128'(cyc), 128'(4 * (nr + 1)));
            seen_valid = 1'b1;
         end
         if (abort_idx >= 0 && rk_valid && idx == abort_idx) begin
            abort    = 1'b1;
            rk_ready = 1'b1;
            @(posedge clk);
            @(negedge clk);
            abort    = 1'b0;
            rk_ready = 1'b0;
            chk("abort_busy", 128'(busy), 128'd0);
            chk("abort_rk_valid", 128'(rk_valid), 128'd0);
            chk("abort_key_ready", 128'(key_ready), 128'd1);
            exp_q.delete();
            return;
         end
         rdy = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
         rk_ready = rdy;
         if (rk_valid && rdy) begin
            if (idx == 0) first = rk_data;
            last = rk_data;
            void'(exp_q.pop_front());
            idx++;
            if (idx == nr + 1) done = 1'b1;
         end
         @(posedge clk);
         @(negedge clk);
         cyc++;
      end
      rk_ready = 1'b0;
      chk("stream_complete", 128'(done), 128'd1);
      chk("end_busy", 128'(busy), 128'd0);
      chk("end_rk_valid", 128'(rk_valid), 128'd0);
      chk("end_key_ready", 128'(key_ready), 128'd1);
   endtask

`ifdef AES_KEY_EXP_STORE_EN
   task automatic read_tbl(input logic [3:0] a, input logic [127:0] exp, input string tag);
      rd_addr = a;
      @(posedge clk);
      @(negedge clk);
      chk(tag, rd_data, exp);
   endtask
`endif

   initial begin
      logic [127:0] first;
      logic [127:0] last;
      logic [255:0] k;
      logic [1:0]   m;
      int nr;

      build_sbox();

      // Reset
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_key_ready", 128'(key_ready), 128'd0);
      chk("rst_rk_valid", 128'(rk_valid), 128'd0);
      chk("rst_busy", 128'(busy), 128'd0);
      chk("rst_err", 128'(err), 128'd0);
      chk("rst_rk_data", rk_data, 128'd0);
      chk("rst_rk_idx", 128'(rk_idx), 128'd0);
      chk("rst_rk_last", 128'(rk_last), 128'd0);
      rst_n = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("post_rst_key_ready", 128'(key_ready), 128'd1);

      // AES-128, 000102..0f, no backpressure; random unused LSBs
      k = {128'h000102030405060708090a0b0c0d0e0f, 128'(rand256())};
      nr = model(2'd0, k);
      send_key(2'd0, k);
      run_stream(nr, 1'b0, -1, first, last);
      chk("aes128_a_rk10", last, 128'h13111d7fe3944a17f307a78b4d2b30c5);

      // AES-128, 2b7e15...
      k = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'd0};
      nr = model(2'd0, k);
      send_key(2'd0, k);
      run_stream(nr, 1'b0, -1, first, last);
      chk("aes128_b_rk0", first, 128'h2b7e151628aed2a6abf7158809cf4f3c);
      chk("aes128_b_rk10", last, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

      // AES-192 with random stalls
      k = {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'(rand256())};
      nr = model(2'd1, k);
      send_key(2'd1, k);
      run_stream(nr, 1'b1, -1, first, last);
      chk("aes192_rk12", last, 128'ha4970a331a78dc09c418c271e3a41d5d);

      // AES-256 with random stalls
      k = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
      nr = model(2'd2, k);
      send_key(2'd2, k);
      run_stream(nr, 1'b1, -1, first, last);
      chk("aes256_rk14", last, 128'h24fc79ccbf0979e9371ac23c6d68de36);
`ifdef AES_KEY_EXP_STORE_EN
      chk("tbl_valid_after_run", 128'(tbl_valid), 128'd1);
      read_tbl(4'd14, 128'h24fc79ccbf0979e9371ac23c6d68de36, "tbl_rd14");
      read_tbl(4'd15, 128'd0, "tbl_rd15");
      read_tbl(4'd0, exp_rk[0], "tbl_rd0");
      read_tbl(4'd7, exp_rk[7], "tbl_rd7");
`endif

      // Reserved mode: err pulse, engine stays idle
      @(negedge clk);
      key_valid = 1'b1;
      key_mode  = 2'd3;
      key       = rand256();
      @(posedge clk);
      @(negedge clk);
      key_valid = 1'b0;
      chk("bad_mode_err", 128'(err), 128'd1);
      chk("bad_mode_busy", 128'(busy), 128'd0);
      chk("bad_mode_key_ready", 128'(key_ready), 128'd1);
      @(posedge clk);
      @(negedge clk);
      chk("bad_mode_err_clears", 128'(err), 128'd0);

      // Abort mid-stream, then a fresh AES-128 key
      k = rand256();
      nr = model(2'd2, k);
      send_key(2'd2, k);
      run_stream(nr, 1'b1, 5, first, last);
`ifdef AES_KEY_EXP_STORE_EN
      chk("tbl_valid_after_abort", 128'(tbl_valid), 128'd0);
      read_tbl(4'd0, 128'd0, "tbl_rd_invalid");
`endif
      k = rand256();
      nr = model(2'd0, k);
      send_key(2'd0, k);
      run_stream(nr, 1'b0, -1, first, last);
      chk("post_abort_rk0", first, k[255:128]);

      // Random keys, random modes, random backpressure
      for (int n = 0; n < 6; n++) begin
         m = 2'($urandom_range(0, 2));
         k = rand256();
         nr = model(m, k);
         send_key(m, k);
         run_stream(nr, 1'($urandom_range(0, 1)), -1, first, last);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
